bp_cfg_loader: RTL and testbench



---
 rtl/bp_cfg_link_pkg.sv | 27 ++
 rtl/bp_cfg_loader_if.sv | 25 ++
 rtl/bp_cfg_loader.sv | 125 ++++++++++++
 tb/tb_bp_cfg_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_link_pkg.sv
// Shared definitions for the boot-time config link: sequencer states,
// config register address map and the default-width link beat.
package bp_cfg_link_pkg;

    typedef enum logic [2:0] {
        e_reset       = 3'd0,
        e_freeze      = 3'd1,
        e_core_id     = 3'd2,
        e_ucode_fetch = 3'd3,
        e_ucode_send  = 3'd4,
        e_unfreeze    = 3'd5,
        e_done        = 3'd6
    } bp_cfg_loader_state_e;

    localparam logic [15:0] bp_cfg_reg_freeze_gp       = 16'h0000;
    localparam logic [15:0] bp_cfg_reg_core_id_base_gp = 16'h0010;
    localparam logic [15:0] bp_cfg_reg_ucode_base_gp   = 16'h8000;

    localparam int bp_cfg_addr_width_gp = 16;
    localparam int bp_cfg_data_width_gp = 64;

    typedef struct packed {
        logic [bp_cfg_addr_width_gp-1:0] addr;
        logic [bp_cfg_data_width_gp-1:0] data;
    } bp_cfg_link_s;

endpackage

// File: rtl/bp_cfg_loader_if.sv
// Config-link write channel plus the microcode ROM read port seen by the loader.
interface bp_cfg_loader_if #(
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int rom_addr_width_p = 8,
    parameter int cce_instr_width_p = 48
);
    logic                         cfg_v_o;
    logic [cfg_addr_width_p-1:0]  cfg_addr_o;
    logic [cfg_data_width_p-1:0]  cfg_data_o;
    logic                         cfg_ready_i;
    logic [rom_addr_width_p-1:0]  rom_addr_o;
    logic                         rom_v_o;
    logic [cce_instr_width_p-1:0] rom_data_i;

    modport master (
        output cfg_v_o, cfg_addr_o, cfg_data_o, rom_addr_o, rom_v_o,
        input  cfg_ready_i, rom_data_i
    );

    modport slave (
        input  cfg_v_o, cfg_addr_o, cfg_data_o, rom_addr_o, rom_v_o,
        output cfg_ready_i, rom_data_i
    );
endinterface

// File: rtl/bp_cfg_loader.sv
// Boot config sequencer: after reset writes freeze, per-core IDs, CCE
// microcode (fetched from an external sync ROM) and unfreeze, then holds done.
module bp_cfg_loader
    import bp_cfg_link_pkg::*;
#(
    parameter int num_core_p              = 1,
    parameter int num_cce_instr_ram_els_p = 256,
    parameter int cce_instr_width_p       = 48,
    parameter int cfg_addr_width_p        = 16,
    parameter int cfg_data_width_p        = 64
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    bp_cfg_loader_if.master  cfg_if,
    output logic             done_o
);

    localparam int core_cnt_w  = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int ucode_cnt_w = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1;

    localparam logic [core_cnt_w-1:0]  core_last_lp  = core_cnt_w'(num_core_p - 1);
    localparam logic [ucode_cnt_w-1:0] ucode_last_lp = ucode_cnt_w'(num_cce_instr_ram_els_p - 1);

    bp_cfg_loader_state_e          r_state;
    logic [core_cnt_w-1:0]         r_core_cnt;
    logic [ucode_cnt_w-1:0]        r_ucode_cnt;
    logic [cce_instr_width_p-1:0]  r_ucode_data;
    logic                          r_fresh;   // first cycle of e_ucode_send: ROM output is live

    logic                          w_cfg_v;
    logic [cfg_addr_width_p-1:0]   w_cfg_addr;
    logic [cfg_data_width_p-1:0]   w_cfg_data;
    logic                          w_xfer;
    logic [cce_instr_width_p-1:0]  w_ucode_word;

    assign w_xfer       = w_cfg_v & cfg_if.cfg_ready_i;
    // ROM data is only valid the cycle after the fetch; afterwards use the held copy
    assign w_ucode_word = r_fresh ? cfg_if.rom_data_i : r_ucode_data;

    // Sequencer state, counters and microcode capture register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= e_reset;
            r_core_cnt   <= '0;
            r_ucode_cnt  <= '0;
            r_ucode_data <= '0;
            r_fresh      <= 1'b0;
        end else begin
            case (r_state)
                e_reset: r_state <= e_freeze;
                e_freeze: if (w_xfer) begin
                    r_state    <= e_core_id;
                    r_core_cnt <= '0;
                end
                e_core_id: if (w_xfer) begin
                    if (r_core_cnt == core_last_lp) begin
                        r_state     <= e_ucode_fetch;
                        r_ucode_cnt <= '0;
                    end else begin
                        r_core_cnt <= r_core_cnt + core_cnt_w'(1);
                    end
                end
                e_ucode_fetch: begin
                    r_state <= e_ucode_send;
                    r_fresh <= 1'b1;
                end
                e_ucode_send: begin
                    if (r_fresh) begin
                        r_ucode_data <= cfg_if.rom_data_i;
                        r_fresh      <= 1'b0;
                    end
                    if (w_xfer) begin
                        if (r_ucode_cnt == ucode_last_lp) begin
                            r_state <= e_unfreeze;
                        end else begin
                            r_ucode_cnt <= r_ucode_cnt + ucode_cnt_w'(1);
                            r_state     <= e_ucode_fetch;
                        end
                    end
                end
                e_unfreeze: if (w_xfer) r_state <= e_done;
                e_done:     r_state <= e_done;
                default:    r_state <= e_reset;
            endcase
        end
    end

    // Write beat decoded purely from registered state, so ready never reaches it
    always_comb begin
        w_cfg_v    = 1'b0;
        w_cfg_addr = '0;
        w_cfg_data = '0;
        case (r_state)
            e_freeze: begin
                w_cfg_v    = 1'b1;
                w_cfg_addr = cfg_addr_width_p'(bp_cfg_reg_freeze_gp);
                w_cfg_data = cfg_data_width_p'(1);
            end
            e_core_id: begin
                w_cfg_v    = 1'b1;
                w_cfg_addr = cfg_addr_width_p'(bp_cfg_reg_core_id_base_gp) + cfg_addr_width_p'(r_core_cnt);
                w_cfg_data = cfg_data_width_p'(r_core_cnt);
            end
            e_ucode_send: begin
                w_cfg_v    = 1'b1;
                w_cfg_addr = cfg_addr_width_p'(bp_cfg_reg_ucode_base_gp) + cfg_addr_width_p'(r_ucode_cnt);
                w_cfg_data = cfg_data_width_p'(w_ucode_word);
            end
            e_unfreeze: begin
                w_cfg_v    = 1'b1;
                w_cfg_addr = cfg_addr_width_p'(bp_cfg_reg_freeze_gp);
                w_cfg_data = '0;
            end
            default: ;
        endcase
    end

    assign cfg_if.cfg_v_o    = w_cfg_v;
    assign cfg_if.cfg_addr_o = w_cfg_addr;
    assign cfg_if.cfg_data_o = w_cfg_data;
    assign cfg_if.rom_v_o    = (r_state == e_ucode_fetch);
    assign cfg_if.rom_addr_o = (r_state == e_ucode_fetch) ? r_ucode_cnt : '0;
    assign done_o            = (r_state == e_done);

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Scoreboard bench: expected config writes are queued when a run is launched
// and popped as the loader hands them over the link.
module tb_bp_cfg_loader;
    import bp_cfg_link_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] rom_word(input int i);
        return {16'(i) ^ 16'hC3A5, 32'(i) * 32'h9E3779B9};
    endfunction

    // ---------------- DUT A: default config ----------------
    logic rst_a, done_a, garb;
    logic [47:0] roma_q, garb_val;
    bp_cfg_loader_if #(.cfg_addr_width_p(16), .cfg_data_width_p(64),
                       .rom_addr_width_p(8), .cce_instr_width_p(48)) ifa ();
    bp_cfg_loader #(.num_core_p(1), .num_cce_instr_ram_els_p(256), .cce_instr_width_p(48),
                    .cfg_addr_width_p(16), .cfg_data_width_p(64))
        dut_a (.clk_i(clk), .reset_n_i(rst_a), .cfg_if(ifa), .done_o(done_a));

    always @(posedge clk) if (ifa.rom_v_o) roma_q <= rom_word(int'(ifa.rom_addr_o));
    assign ifa.rom_data_i = garb ? garb_val : roma_q;

    bp_cfg_link_s qa[$];
    logic a_stall = 1'b0;
    logic [15:0] a_paddr;
    logic [63:0] a_pdata;

    always @(negedge clk) begin
        if (rst_a) begin
            if (a_stall) begin
                chk("a_stall_v", 64'(ifa.cfg_v_o), 64'd1);
                chk("a_stall_addr", 64'(ifa.cfg_addr_o), 64'(a_paddr));
                chk("a_stall_data", ifa.cfg_data_o, a_pdata);
            end
            if (ifa.cfg_v_o && ifa.cfg_ready_i) begin
                if (qa.size() == 0) chk("a_extra_write", 64'(ifa.cfg_addr_o), 64'hFFFF_FFFF);
                else begin
                    bp_cfg_link_s e;
                    e = qa.pop_front();
                    chk("a_addr", 64'(ifa.cfg_addr_o), 64'(e.addr));
                    chk("a_data", ifa.cfg_data_o, e.data);
                end
            end
            a_stall <= ifa.cfg_v_o && !ifa.cfg_ready_i;
            a_paddr <= ifa.cfg_addr_o;
            a_pdata <= ifa.cfg_data_o;
        end else a_stall <= 1'b0;
    end

    task automatic push_a();
        qa.delete();
        qa.push_back('{addr: 16'h0000, data: 64'd1});
        qa.push_back('{addr: 16'h0010, data: 64'd0});
        for (int i = 0; i < 256; i++)
            qa.push_back('{addr: 16'h8000 + 16'(i), data: 64'(rom_word(i))});
        qa.push_back('{addr: 16'h0000, data: 64'd0});
    endtask

    // mode 1: ready high; 2: 20-cycle stall on word 2 with ROM garbage; 3: stop at word 100
    task automatic run_a(input int mode, output int cyc);
        int stall_n;
        stall_n = 0;
        cyc = 0;
        ifa.cfg_ready_i = 1'b1;
        garb = 1'b0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (done_a) break;
            if (mode == 3 && ifa.cfg_v_o && ifa.cfg_addr_o == 16'h8064) break;
            if (mode == 2) begin
                if (ifa.cfg_v_o && ifa.cfg_addr_o == 16'h8002) begin
                    garb = (stall_n != 0);
                    ifa.cfg_ready_i = (stall_n == 20);
                    if (stall_n < 20) stall_n++;
                end else begin
                    garb = 1'b0;
                    ifa.cfg_ready_i = 1'b1;
                end
            end
        end
    endtask

    // ---------------- DUT B: 4 cores, 4 ucode words, ready toggling ----------------
    logic rst_b, done_b, b_fin;
    logic [47:0] romb_q;
    bp_cfg_loader_if #(.cfg_addr_width_p(16), .cfg_data_width_p(64),
                       .rom_addr_width_p(2), .cce_instr_width_p(48)) ifb ();
    bp_cfg_loader #(.num_core_p(4), .num_cce_instr_ram_els_p(4), .cce_instr_width_p(48),
                    .cfg_addr_width_p(16), .cfg_data_width_p(64))
        dut_b (.clk_i(clk), .reset_n_i(rst_b), .cfg_if(ifb), .done_o(done_b));

    always @(posedge clk) if (ifb.rom_v_o) romb_q <= rom_word(int'(ifb.rom_addr_o));
    assign ifb.rom_data_i = romb_q;

    bp_cfg_link_s qb[$];
    logic b_stall = 1'b0;
    logic [15:0] b_paddr;
    logic [63:0] b_pdata;

    always @(negedge clk) begin
        if (rst_b) begin
            if (b_stall) begin
                chk("b_stall_v", 64'(ifb.cfg_v_o), 64'd1);
                chk("b_stall_addr", 64'(ifb.cfg_addr_o), 64'(b_paddr));
                chk("b_stall_data", ifb.cfg_data_o, b_pdata);
            end
            if (ifb.cfg_v_o && ifb.cfg_ready_i) begin
                if (qb.size() == 0) chk("b_extra_write", 64'(ifb.cfg_addr_o), 64'hFFFF_FFFF);
                else begin
                    bp_cfg_link_s e;
                    e = qb.pop_front();
                    chk("b_addr", 64'(ifb.cfg_addr_o), 64'(e.addr));
                    chk("b_data", ifb.cfg_data_o, e.data);
                end
            end
            b_stall <= ifb.cfg_v_o && !ifb.cfg_ready_i;
            b_paddr <= ifb.cfg_addr_o;
            b_pdata <= ifb.cfg_data_o;
        end else b_stall <= 1'b0;
    end

    initial begin
        int cyc;
        b_fin = 1'b0;
        rst_b = 1'b0;
        ifb.cfg_ready_i = 1'b1;
        qb.push_back('{addr: 16'h0000, data: 64'd1});
        for (int n = 0; n < 4; n++) qb.push_back('{addr: 16'h0010 + 16'(n), data: 64'(n)});
        for (int i = 0; i < 4; i++) qb.push_back('{addr: 16'h8000 + 16'(i), data: 64'(rom_word(i))});
        qb.push_back('{addr: 16'h0000, data: 64'd0});
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        cyc = 0;
        while (!done_b && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            ifb.cfg_ready_i = ~ifb.cfg_ready_i;
        end
        chk("b_done", 64'(done_b), 64'd1);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        b_fin = 1'b1;
    end

    // ---------------- main sequence on DUT A ----------------
    initial begin
        int cyc;
        rst_a = 1'b0;
        garb = 1'b0;
        garb_val = 48'hDEAD_BEEF_F00D;
        ifa.cfg_ready_i = 1'b1;
        #1;
        chk("rst_cfg_v", 64'(ifa.cfg_v_o), 64'd0);
        chk("rst_cfg_addr", 64'(ifa.cfg_addr_o), 64'd0);
        chk("rst_cfg_data", ifa.cfg_data_o, 64'd0);
        chk("rst_rom_v", 64'(ifa.rom_v_o), 64'd0);
        chk("rst_rom_addr", 64'(ifa.rom_addr_o), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);

        // full default run, ready high
        push_a();
        @(posedge clk); #1 rst_a = 1'b1;
        run_a(1, cyc);
        chk("p1_done_cycle", 64'(cyc), 64'd516);
        chk("p1_queue_empty", 64'(qa.size()), 64'd0);

        // stall on word 2 with ROM garbage after capture
        @(posedge clk); #1 rst_a = 1'b0;
        @(posedge clk); #1;
        chk("p2_rst_done", 64'(done_a), 64'd0);
        garb_val = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        if (garb_val == rom_word(2)) garb_val = ~garb_val;
        push_a();
        rst_a = 1'b1;
        run_a(2, cyc);
        chk("p2_done_cycle", 64'(cyc), 64'd536);
        chk("p2_queue_empty", 64'(qa.size()), 64'd0);

        // async reset during ucode word 100
        @(posedge clk); #1 rst_a = 1'b0;
        @(posedge clk); #1;
        push_a();
        rst_a = 1'b1;
        run_a(3, cyc);
        chk("p3_reached_w100", 64'(ifa.cfg_addr_o), 64'h8064);
        #2 rst_a = 1'b0;
        #1;
        chk("p3_async_cfg_v", 64'(ifa.cfg_v_o), 64'd0);
        chk("p3_async_cfg_addr", 64'(ifa.cfg_addr_o), 64'd0);
        chk("p3_async_cfg_data", ifa.cfg_data_o, 64'd0);
        chk("p3_async_rom_v", 64'(ifa.rom_v_o), 64'd0);
        chk("p3_async_rom_addr", 64'(ifa.rom_addr_o), 64'd0);
        chk("p3_async_done", 64'(done_a), 64'd0);
        @(posedge clk); #1;
        push_a();
        rst_a = 1'b1;
        run_a(1, cyc);
        chk("p3_done_cycle", 64'(cyc), 64'd516);
        chk("p3_queue_empty", 64'(qa.size()), 64'd0);

        // after done: random ready must not restart anything
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            ifa.cfg_ready_i = 1'($urandom);
            chk("p4_cfg_v", 64'(ifa.cfg_v_o), 64'd0);
            chk("p4_done", 64'(done_a), 64'd1);
        end

        chk("b_finished", 64'(b_fin), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
